// File: rtl/regfile_writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_unit_if
// Brief   : Result-source, reservation and register-file write port bundle.
// Revision: 1.0 - initial release
// ============================================================================
interface regfile_writeback_unit_if #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               ld_valid_i;
  logic [4:0]         ld_rd_i;
  logic [DWIDTH-1:0]  ld_data_i;
  logic               ld_ready_o;
  logic               alu_valid_i;
  logic [4:0]         alu_rd_i;
  logic [DWIDTH-1:0]  alu_data_i;
  logic               alu_ready_o;
  logic               reserve_i;
  logic [4:0]         reserve_rd_i;
  logic [4:0]         rd_o;
  logic [DWIDTH-1:0]  datawb_o;
  logic               regwren_o;
  logic [31:0]        busy_o;
  logic [c_cnt_w-1:0] count_o;
  logic               sb_overflow_o;

  modport master (
    output ld_valid_i, ld_rd_i, ld_data_i, alu_valid_i, alu_rd_i, alu_data_i,
           reserve_i, reserve_rd_i,
    input  ld_ready_o, alu_ready_o, rd_o, datawb_o, regwren_o, busy_o,
           count_o, sb_overflow_o
  );

  modport slave (
    input  ld_valid_i, ld_rd_i, ld_data_i, alu_valid_i, alu_rd_i, alu_data_i,
           reserve_i, reserve_rd_i,
    output ld_ready_o, alu_ready_o, rd_o, datawb_o, regwren_o, busy_o,
           count_o, sb_overflow_o
  );
endinterface
`default_nettype wire

// File: rtl/regfile_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : regfile_writeback_unit
// Brief   : Merges load/ALU results through a FIFO into the register file
//           write port and tracks pending writes per register.
// Revision: 1.0 - initial release
// ============================================================================
module regfile_writeback_unit #(
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  wire logic             clk,
  input  wire logic             rst,
  regfile_writeback_unit_if.slave bus
);
  localparam int c_addr_w = $clog2(DEPTH);
  localparam int c_cnt_w  = c_addr_w + 1;

  logic [4:0]          r_mem_rd   [DEPTH];
  logic [DWIDTH-1:0]   r_mem_data [DEPTH];
  logic [c_addr_w-1:0] r_head, r_tail;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_sb_overflow;

  logic [c_cnt_w-1:0]  w_free;
  logic                w_ld_ready, w_alu_ready;
  logic                w_ld_push, w_alu_push, w_pop, w_empty;
  logic [c_addr_w-1:0] w_alu_slot;
  logic [4:0]          w_rd_head;
  logic [31:0]         w_busy, w_ovf_hit;

  // Space is judged on current occupancy only; the same-cycle pop is not credited.
  assign w_free      = c_cnt_w'(DEPTH) - r_count;
  assign w_ld_ready  = (w_free != '0);
  assign w_alu_ready = (w_free >= c_cnt_w'(2)) ||
                       ((w_free == c_cnt_w'(1)) && !bus.ld_valid_i);

  assign w_ld_push  = bus.ld_valid_i  && w_ld_ready  && (bus.ld_rd_i  != 5'd0);
  assign w_alu_push = bus.alu_valid_i && w_alu_ready && (bus.alu_rd_i != 5'd0);
  assign w_empty    = (r_count == '0);
  assign w_pop      = !w_empty;
  assign w_alu_slot = r_tail + c_addr_w'(w_ld_push);
  assign w_rd_head  = w_empty ? 5'd0 : r_mem_rd[r_head];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_addr_w'(w_pop);
      r_tail  <= r_tail + c_addr_w'(w_ld_push) + c_addr_w'(w_alu_push);
      r_count <= r_count + c_cnt_w'(w_ld_push) + c_cnt_w'(w_alu_push)
                 - c_cnt_w'(w_pop);
    end
  end

  // Load lands first so same-rd pairs drain load-then-ALU.
  always_ff @(posedge clk) begin
    if (w_ld_push) begin
      r_mem_rd[r_tail]   <= bus.ld_rd_i;
      r_mem_data[r_tail] <= bus.ld_data_i;
    end
    if (w_alu_push) begin
      r_mem_rd[w_alu_slot]   <= bus.alu_rd_i;
      r_mem_data[w_alu_slot] <= bus.alu_data_i;
    end
  end

  genvar gi;
  for (gi = 0; gi < 32; gi++) begin : g_sb
    if (gi == 0) begin : g_x0
      assign w_busy[gi]    = 1'b0;
      assign w_ovf_hit[gi] = 1'b0;
    end else begin : g_cnt
      logic [2:0] r_cnt;
      logic       w_inc, w_dec;

      assign w_inc = bus.reserve_i && (bus.reserve_rd_i == 5'(gi));
      assign w_dec = w_pop && (w_rd_head == 5'(gi));
      assign w_ovf_hit[gi] = w_inc && !w_dec && (r_cnt == 3'd7);
      assign w_busy[gi]    = (r_cnt != 3'd0);

      // Saturating in both directions; a matched reserve+pop cancels out.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_cnt <= 3'd0;
        end else if (w_inc && !w_dec && (r_cnt != 3'd7)) begin
          r_cnt <= r_cnt + 3'd1;
        end else if (w_dec && !w_inc && (r_cnt != 3'd0)) begin
          r_cnt <= r_cnt - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sb_overflow <= 1'b0;
    end else begin
      r_sb_overflow <= r_sb_overflow | (|w_ovf_hit);
    end
  end

  assign bus.ld_ready_o    = w_ld_ready;
  assign bus.alu_ready_o   = w_alu_ready;
  assign bus.regwren_o     = w_pop;
  assign bus.rd_o          = w_rd_head;
  assign bus.datawb_o      = w_empty ? '0 : r_mem_data[r_head];
  assign bus.busy_o        = w_busy;
  assign bus.count_o       = r_count;
  assign bus.sb_overflow_o = r_sb_overflow;
endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_writeback_unit
// Brief   : Scenario tasks plus randomized traffic against a queue-based model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_regfile_writeback_unit;
  localparam int DWIDTH  = 32;
  localparam int DEPTH   = 4;
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [4:0]        rd;
    logic [DWIDTH-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  regfile_writeback_unit_if #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) bus ();
  regfile_writeback_unit #(.DWIDTH(DWIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   vectors = 0;
  int   errors  = 0;
  ent_t q[$];
  int   sb[32];
  bit   ovf;
  logic exp_ldr, exp_alur, obs_ldr, obs_alur;

  function automatic logic [31:0] m_busy();
    logic [31:0] b = '0;
    for (int r = 1; r < 32; r++) b[r] = (sb[r] != 0);
    return b;
  endfunction

  function automatic logic [4:0] m_rd();
    return (q.size() != 0) ? q[0].rd : 5'd0;
  endfunction

  function automatic logic [DWIDTH-1:0] m_data();
    return (q.size() != 0) ? q[0].data : '0;
  endfunction

  task automatic model_reset();
    q.delete();
    for (int r = 0; r < 32; r++) sb[r] = 0;
    ovf = 1'b0;
  endtask

  // Drives one cycle, records readies before the edge, advances the model.
  task automatic step(input logic lv, input logic [4:0] lrd, input logic [DWIDTH-1:0] ldat,
                      input logic av, input logic [4:0] ard, input logic [DWIDTH-1:0] adat,
                      input logic rv, input logic [4:0] rrd, input logic rs);
    ent_t       head;
    int         free;
    logic       popped, inc, dec;
    logic [4:0] prd;
    rst = rs;
    bus.ld_valid_i  = lv;  bus.ld_rd_i  = lrd; bus.ld_data_i  = ldat;
    bus.alu_valid_i = av;  bus.alu_rd_i = ard; bus.alu_data_i = adat;
    bus.reserve_i   = rv;  bus.reserve_rd_i = rrd;
    #1;
    free     = DEPTH - q.size();
    exp_ldr  = (free >= 1);
    exp_alur = (free >= 2) || (free == 1 && !lv);
    obs_ldr  = bus.ld_ready_o;
    obs_alur = bus.alu_ready_o;
    if (rs) begin
      model_reset();
    end else begin
      popped = (q.size() != 0);
      prd    = 5'd0;
      if (popped) begin
        head = q.pop_front();
        prd  = head.rd;
      end
      if (lv && exp_ldr && lrd != 5'd0)  q.push_back(ent_t'{rd: lrd, data: ldat});
      if (av && exp_alur && ard != 5'd0) q.push_back(ent_t'{rd: ard, data: adat});
      for (int r = 1; r < 32; r++) begin
        inc = rv && (rrd == 5'(r));
        dec = popped && (prd == 5'(r));
        if (inc && !dec) begin
          if (sb[r] == 7) ovf = 1'b1;
          else sb[r]++;
        end else if (dec && !inc && sb[r] > 0) begin
          sb[r]--;
        end
      end
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 5'd4, 32'h1, 1, 5'd6, 32'h2, 1, 5'd4, 1);
    step(1, 5'd4, 32'h1, 1, 5'd6, 32'h2, 1, 5'd4, 1);
    vectors++; if (bus.regwren_o !== 1'b0) begin errors++; $display("FAIL reset_regwren: got %b expected 0", bus.regwren_o); end
    vectors++; if (bus.rd_o !== 5'd0) begin errors++; $display("FAIL reset_rd: got %0d expected 0", bus.rd_o); end
    vectors++; if (bus.datawb_o !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus.datawb_o); end
    vectors++; if (bus.busy_o !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h expected 0", bus.busy_o); end
    vectors++; if (bus.count_o !== '0) begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count_o); end
    vectors++; if (bus.sb_overflow_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", bus.sb_overflow_o); end
    idle();
    vectors++; if (obs_ldr !== 1'b1) begin errors++; $display("FAIL reset_ldready: got %b expected 1", obs_ldr); end
  endtask

  task automatic test_single_alu();
    step(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0);
    vectors++; if (bus.regwren_o !== 1'b1) begin errors++; $display("FAIL single_wren: got %b expected 1", bus.regwren_o); end
    vectors++; if (bus.rd_o !== 5'd5) begin errors++; $display("FAIL single_rd: got %0d expected 5", bus.rd_o); end
    vectors++; if (bus.datawb_o !== 32'hDEADBEEF) begin errors++; $display("FAIL single_data: got %h expected deadbeef", bus.datawb_o); end
    idle();
    vectors++; if (bus.regwren_o !== 1'b0 || bus.count_o !== '0) begin errors++; $display("FAIL single_empty: got wren=%b count=%0d expected 0/0", bus.regwren_o, bus.count_o); end
  endtask

  task automatic test_simultaneous();
    step(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0, 0, 0);
    vectors++; if (obs_ldr !== 1'b1 || obs_alur !== 1'b1) begin errors++; $display("FAIL simul_ready: got %b%b expected 11", obs_ldr, obs_alur); end
    vectors++; if (bus.count_o !== c_cnt_w'(2) || bus.rd_o !== 5'd3 || bus.datawb_o !== 32'h11) begin errors++; $display("FAIL simul_first: got count=%0d rd=%0d data=%h expected 2/3/11", bus.count_o, bus.rd_o, bus.datawb_o); end
    idle();
    vectors++; if (bus.count_o !== c_cnt_w'(1) || bus.rd_o !== 5'd3 || bus.datawb_o !== 32'h22) begin errors++; $display("FAIL simul_second: got count=%0d rd=%0d data=%h expected 1/3/22", bus.count_o, bus.rd_o, bus.datawb_o); end
    idle();
    vectors++; if (bus.count_o !== '0 || bus.regwren_o !== 1'b0) begin errors++; $display("FAIL simul_drained: got count=%0d wren=%b expected 0/0", bus.count_o, bus.regwren_o); end
  endtask

  task automatic test_back_pressure();
    bit saw_alu_drop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1, 5'($urandom_range(1, 31)), $urandom, 1, 5'($urandom_range(1, 31)), $urandom, 0, 0, 0);
      if (obs_ldr && !obs_alur) saw_alu_drop = 1'b1;
      vectors++; if (obs_ldr !== exp_ldr || obs_alur !== exp_alur) begin errors++; $display("FAIL bp_ready[%0d]: got %b%b expected %b%b", i, obs_ldr, obs_alur, exp_ldr, exp_alur); end
      vectors++; if (bus.count_o !== c_cnt_w'(q.size()) || bus.rd_o !== m_rd() || bus.datawb_o !== m_data()) begin errors++; $display("FAIL bp_head[%0d]: got count=%0d rd=%0d data=%h expected %0d/%0d/%h", i, bus.count_o, bus.rd_o, bus.datawb_o, q.size(), m_rd(), m_data()); end
    end
    vectors++; if (saw_alu_drop !== 1'b1) begin errors++; $display("FAIL bp_alu_drop: got %b expected 1", saw_alu_drop); end
    for (int i = 0; i < DEPTH + 1; i++) begin
      idle();
      vectors++; if (bus.rd_o !== m_rd() || bus.datawb_o !== m_data() || bus.regwren_o !== (q.size() != 0)) begin errors++; $display("FAIL bp_drain[%0d]: got rd=%0d data=%h expected %0d/%h", i, bus.rd_o, bus.datawb_o, m_rd(), m_data()); end
    end
  endtask

  task automatic test_x0();
    step(1, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0, 0);
    vectors++; if (obs_ldr !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b expected 1", obs_ldr); end
    vectors++; if (bus.count_o !== '0 || bus.regwren_o !== 1'b0) begin errors++; $display("FAIL x0_queue: got count=%0d wren=%b expected 0/0", bus.count_o, bus.regwren_o); end
    idle();
  endtask

  task automatic test_scoreboard();
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    vectors++; if (bus.busy_o[7] !== 1'b1) begin errors++; $display("FAIL sb_reserve: got %b expected 1", bus.busy_o[7]); end
    step(0, 0, 0, 1, 5'd7, 32'h70, 0, 0, 0);
    step(0, 0, 0, 1, 5'd7, 32'h71, 0, 0, 0);
    vectors++; if (bus.busy_o[7] !== 1'b1) begin errors++; $display("FAIL sb_first_pop: got %b expected 1", bus.busy_o[7]); end
    idle();
    vectors++; if (bus.busy_o[7] !== 1'b0) begin errors++; $display("FAIL sb_second_pop: got %b expected 0", bus.busy_o[7]); end
    step(0, 0, 0, 1, 5'd7, 32'h72, 1, 5'd7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 5'd7, 0);
    vectors++; if (bus.busy_o[7] !== 1'b1 || bus.busy_o !== m_busy()) begin errors++; $display("FAIL sb_cancel: got %h expected %h", bus.busy_o, m_busy()); end
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0, 0, 0, 1, 5'd9, 0);
      vectors++; if (bus.sb_overflow_o !== (i == 7)) begin errors++; $display("FAIL sb_ovf[%0d]: got %b expected %b", i, bus.sb_overflow_o, i == 7); end
    end
    step(0, 0, 0, 0, 0, 0, 1, 5'd0, 0);
    vectors++; if (bus.busy_o !== m_busy() || bus.busy_o[0] !== 1'b0) begin errors++; $display("FAIL sb_x0: got %h expected %h", bus.busy_o, m_busy()); end
  endtask

  task automatic test_reset_mid();
    step(1, 5'd1, 32'hA1, 1, 5'd2, 32'hA2, 1, 5'd3, 0);
    step(1, 5'd4, 32'hA3, 1, 5'd5, 32'hA4, 0, 0, 0);
    vectors++; if (bus.count_o !== c_cnt_w'(3) || bus.regwren_o !== 1'b1) begin errors++; $display("FAIL mid_fill: got count=%0d wren=%b expected 3/1", bus.count_o, bus.regwren_o); end
    step(1, 5'd6, 32'hA5, 1, 5'd8, 32'hA6, 1, 5'd6, 1);
    vectors++; if (bus.count_o !== '0 || bus.busy_o !== 32'h0 || bus.regwren_o !== 1'b0 || bus.sb_overflow_o !== 1'b0) begin errors++; $display("FAIL mid_reset: got count=%0d busy=%h wren=%b ovf=%b expected 0/0/0/0", bus.count_o, bus.busy_o, bus.regwren_o, bus.sb_overflow_o); end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 6), 5'($urandom_range(0, 9)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 9)), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 9)), 0);
      vectors++; if (obs_ldr !== exp_ldr || obs_alur !== exp_alur) begin errors++; $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", i, obs_ldr, obs_alur, exp_ldr, exp_alur); end
      vectors++; if (bus.count_o !== c_cnt_w'(q.size()) || bus.regwren_o !== (q.size() != 0)) begin errors++; $display("FAIL rnd_count[%0d]: got %0d expected %0d", i, bus.count_o, q.size()); end
      vectors++; if (bus.rd_o !== m_rd() || bus.datawb_o !== m_data()) begin errors++; $display("FAIL rnd_head[%0d]: got %0d/%h expected %0d/%h", i, bus.rd_o, bus.datawb_o, m_rd(), m_data()); end
      vectors++; if (bus.busy_o !== m_busy() || bus.sb_overflow_o !== ovf) begin errors++; $display("FAIL rnd_sb[%0d]: got %h/%b expected %h/%b", i, bus.busy_o, bus.sb_overflow_o, m_busy(), ovf); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_back_pressure();
    test_x0();
    test_scoreboard();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
`default_nettype wire
